// File: rtl/matmul_sequencer.sv
// Sequencer for the 16-lane dot-product datapath: issues ROM read beats, tracks
// the ROM/adder-tree latency, accumulates the tree output and reports a cycle count.
module matmul_sequencer #(
  parameter int LANES    = 16,
  parameter int A_DEPTH  = 4096,
  parameter int B_DEPTH  = 64,
  parameter int PIPE_LAT = 2,
  parameter int A_AW     = 12,
  parameter int B_AW     = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0]     tree_sum,
  output logic            rd_en,
  output logic [A_AW-1:0] a_addr,
  output logic [B_AW-1:0] b_addr,
  output logic            acc_en,
  output logic            busy,
  output logic            done,
  output logic [15:0]     final_sum,
  output logic [15:0]     cycle_count
);

  localparam int NB = A_DEPTH / LANES;

  localparam logic [A_AW-1:0] LAST_BEAT = A_AW'(NB - 1);
  localparam logic [A_AW-1:0] A_STEP    = A_AW'(LANES);
  // B address wraps by plain truncation because B_DEPTH is a power of two.
  localparam logic [B_AW-1:0] B_STEP    = B_AW'(LANES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q,  state_d;
  logic [A_AW-1:0]     beat_q,   beat_d;
  logic                rd_en_q,  rd_en_d;
  logic [A_AW-1:0]     a_addr_q, a_addr_d;
  logic [B_AW-1:0]     b_addr_q, b_addr_d;
  logic [PIPE_LAT-1:0] pipe_q,   pipe_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;
  logic [15:0]         sum_q,    sum_d;
  logic [15:0]         count_q,  count_d;
  logic                acc_en_s;

  assign acc_en_s = pipe_q[PIPE_LAT-1];

  // Next-state logic: FSM, beat/address generation, valid pipe, accumulator, counter.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    pipe_d   = (pipe_q << 1) | PIPE_LAT'(rd_en_q);

    if (acc_en_s) begin
      sum_d = sum_q + tree_sum;
    end else begin
      sum_d = sum_q;
    end

    if (busy_q && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          beat_d   = {A_AW{1'b0}};
          a_addr_d = {A_AW{1'b0}};
          b_addr_d = {B_AW{1'b0}};
          sum_d    = 16'h0000;
          count_d  = 16'h0000;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_DRAIN;
        end else begin
          beat_d   = beat_q + A_AW'(1);
          a_addr_d = a_addr_q + A_STEP;
          b_addr_d = b_addr_q + B_STEP;
        end
      end
      S_DRAIN: begin
        // Pipe empties on this edge: the final beat is being accumulated now.
        if (pipe_d == {PIPE_LAT{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_en_d = (state_d == S_ISSUE);
    busy_d  = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      beat_q   <= {A_AW{1'b0}};
      rd_en_q  <= 1'b0;
      a_addr_q <= {A_AW{1'b0}};
      b_addr_q <= {B_AW{1'b0}};
      pipe_q   <= {PIPE_LAT{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= 16'h0000;
      count_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      rd_en_q  <= rd_en_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      pipe_q   <= pipe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign a_addr      = a_addr_q;
  assign b_addr      = b_addr_q;
  assign acc_en      = acc_en_s;
  assign busy        = busy_q;
  assign done        = done_q;
  assign final_sum   = sum_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: default-size instance plus a small
// instance (A_DEPTH=64, B_DEPTH=32) for address-wrap and pipe-delay checks.
module tb_matmul_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        s_start;
  logic [15:0] ts_val;

  logic        rd_en, acc_en, busy, done;
  logic [11:0] a_addr;
  logic [5:0]  b_addr;
  logic [15:0] final_sum, cycle_count;

  logic        s_rd_en, s_acc_en, s_busy, s_done;
  logic [5:0]  s_a_addr;
  logic [4:0]  s_b_addr;
  logic [15:0] s_final_sum, s_cycle_count;

  int checks;
  int failures;

  matmul_sequencer u_dut (
    .clock(clock), .reset(reset), .start(start), .tree_sum(ts_val),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr), .acc_en(acc_en),
    .busy(busy), .done(done), .final_sum(final_sum), .cycle_count(cycle_count)
  );

  matmul_sequencer #(
    .LANES(16), .A_DEPTH(64), .B_DEPTH(32), .PIPE_LAT(2), .A_AW(6), .B_AW(5)
  ) u_small (
    .clock(clock), .reset(reset), .start(s_start), .tree_sum(ts_val),
    .rd_en(s_rd_en), .a_addr(s_a_addr), .b_addr(s_b_addr), .acc_en(s_acc_en),
    .busy(s_busy), .done(s_done), .final_sum(s_final_sum), .cycle_count(s_cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Pulses start and watches 300 cycles; cycle 0 is the first busy cycle.
  task automatic run_default(input logic [15:0] ts,
                             output int done_cyc, output int done_cnt,
                             output int rd_cnt, output int acc_cnt,
                             output logic [15:0] fs_done, output logic [15:0] cc_done,
                             output logic busy_done, output int addr_err,
                             output logic [15:0] fs5, output logic [15:0] fs6);
    logic [11:0] ea;
    logic [5:0]  eb;
    done_cyc = -1; done_cnt = 0; rd_cnt = 0; acc_cnt = 0; addr_err = 0;
    fs_done = 16'hDEAD; cc_done = 16'hDEAD; busy_done = 1'bx; fs5 = 16'hDEAD; fs6 = 16'hDEAD;
    ts_val = ts;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c == 5) fs5 = final_sum;
      if (c == 6) fs6 = final_sum;
      if (rd_en === 1'b1) begin
        rd_cnt++;
        ea = 12'(c * 16);
        eb = 6'((c * 16) % 64);
        if ((a_addr !== ea) || (b_addr !== eb)) addr_err++;
      end
      if (acc_en === 1'b1) acc_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc  = c;
          fs_done   = final_sum;
          cc_done   = cycle_count;
          busy_done = busy;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; s_start = 1'b0; ts_val = 16'h0000;
    tick(); tick();
    checks++;
    if ({rd_en, acc_en, busy, done} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0000", {rd_en, acc_en, busy, done});
    end
    checks++;
    if ({a_addr, b_addr, final_sum, cycle_count} !== 50'd0) begin
      failures++; $display("FAIL reset_data: a=%0h b=%0h sum=%0h cnt=%0h expected all 0", a_addr, b_addr, final_sum, cycle_count);
    end
    checks++;
    if ({s_rd_en, s_acc_en, s_busy, s_done, s_a_addr, s_b_addr, s_final_sum, s_cycle_count} !== 47'd0) begin
      failures++; $display("FAIL reset_small: outputs not all zero");
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_run;
    int dc, dn, rc, ac, ae;
    logic [15:0] fsd, ccd, f5, f6;
    logic bd;
    run_default(16'h0001, dc, dn, rc, ac, fsd, ccd, bd, ae, f5, f6);
    checks++; if (dc !== 258) begin failures++; $display("FAIL done_cycle: got %0d expected 258", dc); end
    checks++; if (dn !== 1) begin failures++; $display("FAIL done_pulses: got %0d expected 1", dn); end
    checks++; if (rc !== 256) begin failures++; $display("FAIL rd_en_cycles: got %0d expected 256", rc); end
    checks++; if (ac !== 256) begin failures++; $display("FAIL acc_en_cycles: got %0d expected 256", ac); end
    checks++; if (fsd !== 16'h0100) begin failures++; $display("FAIL final_sum: got %0h expected 0100", fsd); end
    checks++; if (ccd !== 16'h0102) begin failures++; $display("FAIL cycle_count: got %0h expected 0102", ccd); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL busy_at_done: got %b expected 0", bd); end
    checks++; if (ae !== 0) begin failures++; $display("FAIL addr_seq: got %0d bad beats expected 0", ae); end
  endtask

  task automatic test_hold_after_done;
    int errs;
    errs = 0;
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if ((final_sum !== 16'h0100) || (cycle_count !== 16'h0102) || (a_addr !== 12'hFF0) ||
          (b_addr !== 6'h30) || (busy !== 1'b0) || (done !== 1'b0)) errs++;
      tick();
    end
    checks++;
    if (errs !== 0) begin
      failures++; $display("FAIL hold_after_done: got %0d unstable cycles expected 0", errs);
    end
  endtask

  task automatic test_wrap;
    int dc, dn, rc, ac, ae;
    logic [15:0] fsd, ccd, f5, f6;
    logic bd;
    run_default(16'h4000, dc, dn, rc, ac, fsd, ccd, bd, ae, f5, f6);
    checks++; if (f5 !== 16'hC000) begin failures++; $display("FAIL wrap_partial3: got %0h expected c000", f5); end
    checks++; if (f6 !== 16'h0000) begin failures++; $display("FAIL wrap_partial4: got %0h expected 0000", f6); end
    checks++; if (fsd !== 16'h0000) begin failures++; $display("FAIL wrap_final: got %0h expected 0000", fsd); end
    checks++; if (dc !== 258) begin failures++; $display("FAIL wrap_done_cycle: got %0d expected 258", dc); end
  endtask

  task automatic test_small;
    logic        rd_h  [12];
    logic        acc_h [12];
    logic [5:0]  a_h   [12];
    logic [4:0]  b_h   [12];
    logic [5:0]  exp_a [4];
    logic [4:0]  exp_b [4];
    int done_c, seq_err, pipe_err;
    logic [15:0] fs_d, cc_d;
    exp_a[0] = 6'd0; exp_a[1] = 6'd16; exp_a[2] = 6'd32; exp_a[3] = 6'd48;
    exp_b[0] = 5'd0; exp_b[1] = 5'd16; exp_b[2] = 5'd0;  exp_b[3] = 5'd16;
    done_c = -1; seq_err = 0; pipe_err = 0; fs_d = 16'hDEAD; cc_d = 16'hDEAD;
    ts_val = 16'h0001;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      rd_h[c] = s_rd_en; acc_h[c] = s_acc_en; a_h[c] = s_a_addr; b_h[c] = s_b_addr;
      if ((s_done === 1'b1) && (done_c < 0)) begin
        done_c = c; fs_d = s_final_sum; cc_d = s_cycle_count;
      end
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      if (rd_h[c] !== ((c < 4) ? 1'b1 : 1'b0)) seq_err++;
      if ((c < 4) && ((a_h[c] !== exp_a[c]) || (b_h[c] !== exp_b[c]))) seq_err++;
      if (acc_h[c] !== ((c >= 2) ? rd_h[c-2] : 1'b0)) pipe_err++;
    end
    checks++; if (seq_err !== 0) begin failures++; $display("FAIL small_addr_seq: got %0d errors expected 0", seq_err); end
    checks++; if (pipe_err !== 0) begin failures++; $display("FAIL small_acc_delay: got %0d errors expected 0", pipe_err); end
    checks++; if (done_c !== 6) begin failures++; $display("FAIL small_done_cycle: got %0d expected 6", done_c); end
    checks++; if (fs_d !== 16'h0004) begin failures++; $display("FAIL small_sum: got %0h expected 0004", fs_d); end
    checks++; if (cc_d !== 16'h0006) begin failures++; $display("FAIL small_count: got %0h expected 0006", cc_d); end
  endtask

  task automatic test_start_held;
    int dn, busy_err;
    logic [15:0] fs_d, fs_r, cc_r;
    logic bd, b259, r259, b260, r260;
    logic [11:0] a260;
    dn = 0; busy_err = 0; fs_d = 16'hDEAD; fs_r = 16'hDEAD; cc_r = 16'hDEAD;
    bd = 1'bx; b259 = 1'bx; r259 = 1'bx; b260 = 1'bx; r260 = 1'bx; a260 = 12'hBAD;
    ts_val = 16'h0001;
    start = 1'b1;
    tick();
    for (int c = 0; c < 262; c++) begin
      if ((c < 258) && (busy !== 1'b1)) busy_err++;
      if (done === 1'b1) dn++;
      if (c == 258) begin bd = busy; fs_d = final_sum; end
      if (c == 259) begin b259 = busy; r259 = rd_en; end
      if (c == 260) begin b260 = busy; r260 = rd_en; a260 = a_addr; fs_r = final_sum; cc_r = cycle_count; end
      tick();
    end
    start = 1'b0;
    checks++; if (busy_err !== 0) begin failures++; $display("FAIL held_busy: got %0d idle cycles expected 0", busy_err); end
    checks++; if (dn !== 1) begin failures++; $display("FAIL held_done_pulses: got %0d expected 1", dn); end
    checks++; if ({bd, fs_d} !== {1'b0, 16'h0100}) begin failures++; $display("FAIL held_done_state: got busy=%b sum=%0h expected busy=0 sum=0100", bd, fs_d); end
    checks++; if ({b259, r259} !== 2'b00) begin failures++; $display("FAIL held_idle_gap: got %b expected 00", {b259, r259}); end
    checks++;
    if ({b260, r260, a260, fs_r, cc_r} !== {1'b1, 1'b1, 12'h000, 16'h0000, 16'h0000}) begin
      failures++; $display("FAIL held_restart: got busy=%b rd=%b a=%0h sum=%0h cnt=%0h expected 1 1 0 0 0", b260, r260, a260, fs_r, cc_r);
    end
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic test_reset_midrun;
    int dn, dc, dn2, rc, ac, ae;
    logic [15:0] fsd, ccd, f5, f6;
    logic bd;
    logic [11:0] a100;
    dn = 0; a100 = 12'hBAD;
    ts_val = 16'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    a100 = a_addr;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (a100 !== 12'd1600) begin failures++; $display("FAIL midrun_beat100_addr: got %0h expected 640", a100); end
    checks++;
    if ({rd_en, acc_en, busy, done, a_addr, b_addr, final_sum, cycle_count} !== 54'd0) begin
      failures++; $display("FAIL midrun_reset_outputs: a=%0h sum=%0h cnt=%0h busy=%b expected all 0", a_addr, final_sum, cycle_count, busy);
    end
    for (int c = 0; c < 300; c++) begin
      if ((done === 1'b1) || (busy === 1'b1)) dn++;
      tick();
    end
    checks++; if (dn !== 0) begin failures++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", dn); end
    run_default(16'h0001, dc, dn2, rc, ac, fsd, ccd, bd, ae, f5, f6);
    checks++; if (dc !== 258) begin failures++; $display("FAIL post_reset_done_cycle: got %0d expected 258", dc); end
    checks++; if ({fsd, ccd} !== {16'h0100, 16'h0102}) begin failures++; $display("FAIL post_reset_result: got sum=%0h cnt=%0h expected 0100 0102", fsd, ccd); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; start = 1'b0; s_start = 1'b0; ts_val = 16'h0000;
    test_reset();
    test_full_run();
    test_hold_after_done();
    test_wrap();
    test_small();
    test_start_held();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Control block for the 16-lane dot-product datapath: ROM A/B banks, 16 multipliers, adder tree, and final-sum register.
- On a start request it issues one ROM read beat per cycle and generates the A and B base addresses.
- It tracks ROM and adder-tree latency with a valid shift pipeline and accumulates the tree output into final_sum.
- It counts busy cycles, then raises done and holds the result and cycle count for the seven-segment display path.

Parameters:
- LANES, 16, elements consumed per beat (multipliers per beat); power of two.
- A_DEPTH, 4096, total A elements per run; multiple of LANES.
- B_DEPTH, 64, B elements; B address wraps modulo B_DEPTH; power of two, at least LANES.
- PIPE_LAT, 2, cycles from rd_en to the matching tree_sum being valid (ROM read plus tree); at least 1.
- A_AW, 12, A address width, equal to clog2(A_DEPTH).
- B_AW, 6, B address width, equal to clog2(B_DEPTH).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run request, sampled only in IDLE.
- tree_sum  in  16  adder-tree output; valid when acc_en=1.
- rd_en  out  1  ROM read strobe for the current beat.
- a_addr  out  A_AW  base address of ROM A for the beat (lane i reads a_addr+i).
- b_addr  out  B_AW  base address of ROM B for the beat (lane i reads b_addr+i).
- acc_en  out  1  tail of the valid pipe: tree_sum is being accumulated this cycle.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle pulse when the run completes.
- final_sum  out  16  accumulated result; held until the next accepted start.
- cycle_count  out  16  number of busy cycles in the last or current run.

Behaviour:
- Reset (synchronous, active-high) has priority over everything, including mid-run:
  - state=IDLE; valid pipe cleared.
  - rd_en, acc_en, busy, done = 0.
  - a_addr, b_addr, final_sum, cycle_count = 0.
  - An in-flight run is discarded; no done pulse follows.
- States IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 → ISSUE; final_sum, cycle_count, beat counter, a_addr and b_addr all clear to 0.
  - start=0 → stay; outputs hold.
- ISSUE:
  - Cycle 0 is the first busy cycle. rd_en=1 every cycle; beat k is issued in cycle k.
  - a_addr = k*LANES.
  - b_addr = (k*LANES) mod B_DEPTH; wraps silently.
  - After beat NB-1, where NB = A_DEPTH/LANES, → DRAIN.
- DRAIN: rd_en=0; a_addr and b_addr hold their last value. When the final beat's accumulation cycle completes → DONE.
- Valid pipe:
  - PIPE_LAT-deep shift register fed by rd_en; acc_en = last stage.
  - Beat k therefore asserts acc_en in cycle k+PIPE_LAT.
  - When acc_en=1, final_sum <= final_sum + tree_sum at end of cycle, modulo 2^16 (carry dropped).
- DONE: exactly one cycle; done=1, busy=0 → IDLE. start is ignored in DONE and is not queued.
- start while busy is ignored.
- cycle_count increments by 1 each busy cycle, saturating at 16'hFFFF. Total busy cycles = NB+PIPE_LAT; for defaults that is 258 (0x0102).
- For defaults, done is high in cycle 258.

Test Plan:
- Defaults, start pulse, tree_sum=1 whenever acc_en → 256 rd_en cycles; done pulses once in cycle 258; final_sum=0x0100; cycle_count=0x0102; busy low in the done cycle.
- A_DEPTH=64, B_DEPTH=32 → a_addr sequence 0,16,32,48; b_addr sequence 0,16,0,16; acc_en is a delayed copy of rd_en by PIPE_LAT cycles.
- tree_sum=0x4000 for all beats → final_sum wraps to 0x0000; no X or overflow flag.
- start held high across a run and through DONE → exactly one run, single done pulse, then a new run begins on the next IDLE cycle with final_sum cleared.
- reset asserted at beat 100 → next cycle all outputs 0 and state IDLE; no done; a following start gives the normal 258-cycle run.
- After done, start held low for 50 cycles → final_sum, cycle_count and a_addr remain stable.
